// File: rtl/banked_sample_buffer_pkg.sv
// Shared types and default sizing for the banked sample buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sample_buffer_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_BANK_DEPTH = 16384;

  // Read-side FSM: output register empty / RAM read in flight / sample presented.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } rd_state_t;

endpackage

// File: rtl/banked_sample_buffer_if.sv
// Producer/consumer handshake bundle for the banked sample buffer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the write and the read side.
interface banked_sample_buffer_if
  import sample_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  // Environment side: produces samples and consumes them.
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  // Buffer side.
  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/banked_sample_buffer_ram_bank.sv
// Single-port synchronous RAM bank, one access per cycle, write enables all lanes.
// Latency: read data appears on rdata the cycle after en & ~we; contents are not initialised.
// Backpressure: none; the caller arbitrates between write and read for the single port.
module ram_bank
  import sample_buffer_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_BANK_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write when we, otherwise registered read; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/banked_sample_buffer.sv
// Circular sample FIFO over NUM_BANKS single-port RAM banks with a one-word output register.
// Latency: a write into an empty buffer reaches rd_valid 2 cycles after its write edge; 1 sample per 2 cycles max.
// Backpressure: wr_ready = ~full | overwrite (overwrite drops oldest); rd_data held while rd_valid & ~rd_ready.
// Optional feature: define SAMPLE_BUFFER_PEAK_EN to add the running peak |wr_data| output.
module banked_sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int  DATA_W     = DEF_DATA_W,
  parameter int  NUM_BANKS  = DEF_NUM_BANKS,
  parameter int  BANK_DEPTH = DEF_BANK_DEPTH,
  localparam int DEPTH      = NUM_BANKS * BANK_DEPTH,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  overwrite,
  banked_sample_buffer_if.slave bus,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
`ifdef SAMPLE_BUFFER_PEAK_EN
  ,
  output logic [DATA_W-2:0]     peak
`endif
);

  localparam int OFF_W = $clog2(BANK_DEPTH);
  // Bank index is kept at least 1 bit wide so a single-bank build still elaborates.
  localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [BW-1:0]     wr_bank, rd_bank, fetch_bank;
  logic [OFF_W-1:0]  wr_off, rd_off;
  logic              wr_ready, wr_fire, drop, conflict, fetch;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
  rd_state_t         state, state_nxt;

  // Top pointer bits select the bank, the rest address within it.
  assign wr_bank = BW'(wr_ptr >> OFF_W);
  assign rd_bank = BW'(rd_ptr >> OFF_W);
  assign wr_off  = wr_ptr[OFF_W-1:0];
  assign rd_off  = rd_ptr[OFF_W-1:0];

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = ~full | overwrite;
  assign wr_fire  = bus.wr_valid & wr_ready & ~clear;
  // A write while full can only happen in overwrite mode and evicts the oldest word.
  assign drop     = wr_fire & full;
  // Single-port banks: the write owns the port, a same-bank fetch waits a cycle.
  assign conflict = wr_fire & (wr_bank == rd_bank);

  assign bus.wr_ready = wr_ready;
  assign bus.rd_valid = (state == ST_VALID);
  assign bus.rd_data  = rd_data_q;

  // Read FSM next state; fetch pops one RAM word into the output pipeline.
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != '0 && !conflict) begin
          fetch     = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_nxt = ST_VALID;
      end
      ST_VALID: begin
        if (bus.rd_ready) begin
          if (count != '0 && !conflict) begin
            fetch     = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear) begin
      fetch     = 1'b0;
      state_nxt = ST_IDLE;
    end
  end

  // Pointers, occupancy and the overflow pulse; fetch and evict never coincide
  // because a full buffer has wr_ptr == rd_ptr, which is always a bank conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fetch || drop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, wr_fire & ~full} - {{AW{1'b0}}, fetch};
    end
  end

  // FSM state, bank of the in-flight read, and output register capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      fetch_bank <= '0;
      rd_data_q  <= '0;
    end else begin
      state <= state_nxt;
      if (fetch) begin
        fetch_bank <= rd_bank;
      end
      if (state == ST_FETCH && !clear) begin
        rd_data_q <= bank_rdata[fetch_bank];
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_we, bank_re;
    assign bank_we = wr_fire & (wr_bank == BW'(b));
    assign bank_re = fetch & (rd_bank == BW'(b));

    ram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (BANK_DEPTH)
    ) u_ram (
      .clk   (clk),
      .en    (bank_we | bank_re),
      .we    (bank_we),
      .addr  (bank_we ? wr_off : rd_off),
      .wdata (bus.wr_data),
      .rdata (bank_rdata[b])
    );
  end

`ifdef SAMPLE_BUFFER_PEAK_EN
  logic [DATA_W-1:0] mag;
  logic [DATA_W-2:0] mag_sat;

  // Magnitude of the signed sample; only the most negative value sets the top bit, so saturate it.
  always_comb begin
    mag     = bus.wr_data[DATA_W-1] ? (~bus.wr_data + 1'b1) : bus.wr_data;
    mag_sat = mag[DATA_W-1] ? {(DATA_W-1){1'b1}} : mag[DATA_W-2:0];
  end

  // Running maximum magnitude over accepted writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak <= '0;
    end else if (clear) begin
      peak <= '0;
    end else if (wr_fire && (mag_sat > peak)) begin
      peak <= mag_sat;
    end
  end
`endif

endmodule

// File: tb/tb_banked_sample_buffer.sv
// Directed bench for banked_sample_buffer with 4 banks of 4 words (DEPTH 16).
// Latency: n/a.
// Backpressure: rd_ready driven low except while draining.
module tb_banked_sample_buffer;
  import sample_buffer_pkg::*;

  localparam int DATA_W     = 16;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_DEPTH = 4;
  localparam int DEPTH      = 16;
  localparam int AW         = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          overwrite;
  logic [AW:0]   count;
  logic          full, empty, overflow;
`ifdef SAMPLE_BUFFER_PEAK_EN
  logic [DATA_W-2:0] peak;
`endif

  banked_sample_buffer_if #(.DATA_W(DATA_W)) bus ();

  banked_sample_buffer #(
    .DATA_W     (DATA_W),
    .NUM_BANKS  (NUM_BANKS),
    .BANK_DEPTH (BANK_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .overwrite (overwrite),
    .bus       (bus),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
`ifdef SAMPLE_BUFFER_PEAK_EN
    ,
    .peak      (peak)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] got[$];
  int          got_cyc[$];
  int          ov_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.rd_valid && n < 10) begin
      step();
      n++;
    end
    check(tag, {31'd0, bus.rd_valid}, 32'd1);
  endtask

  // Consume with rd_ready high for a fixed window, logging each presented sample.
  task automatic drain(input int cycles);
    got.delete();
    got_cyc.delete();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (bus.rd_valid) begin
        got.push_back(bus.rd_data);
        got_cyc.push_back(i);
      end
      step();
    end
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    clear        = 1'b0;
    overwrite    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_count", 32'(count), 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 1);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    reset_n = 1'b1;
    step();

    // Three samples; writes 2 and 3 hit bank 0 like the pending fetch, so the fetch waits.
    put(16'h0001);
    check("t1_count_w1", 32'(count), 1);
    put(16'h0002);
    check("t1_conflict_count", 32'(count), 2);
    check("t1_conflict_idle", {31'd0, bus.rd_valid}, 0);
    put(16'h0003);
    check("t1_conflict_count2", 32'(count), 3);
    step();
    check("t1_fetch_deferred", 32'(count), 2);
    drain(12);
    check("t1_nread", got.size(), 3);
    check("t1_d0", 32'(got[0]), 1);
    check("t1_d1", 32'(got[1]), 2);
    check("t1_d2", 32'(got[2]), 3);
    check("t1_gap01", got_cyc[1] - got_cyc[0], 2);
    check("t1_gap12", got_cyc[2] - got_cyc[1], 2);
    check("t1_count_end", 32'(count), 0);
    check("t1_empty_end", {31'd0, empty}, 1);

    // Fetch from bank 0 in parallel with a write to bank 1, then clear while VALID.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t2_clear_count", 32'(count), 0);
    for (int i = 0; i < 4; i++) put(16'h0010 + 16'(i));
    check("t2_count4", 32'(count), 4);
    put(16'h0014);
    check("t2_parallel_net0", 32'(count), 4);
    put(16'h0015);
    check("t2_count5", 32'(count), 5);
    check("t2_valid", {31'd0, bus.rd_valid}, 1);
    check("t2_data", 32'(bus.rd_data), 32'h10);
    clear = 1'b1;
    put(16'h0099);
    clear = 1'b0;
    check("t2_clr_rd_valid", {31'd0, bus.rd_valid}, 0);
    check("t2_clr_count", 32'(count), 0);
    check("t2_clr_empty", {31'd0, empty}, 1);

    // Stop-when-full. A marker first parks in the output register so the RAM
    // then takes exactly DEPTH more writes.
    overwrite = 1'b0;
    put(16'hA5A5);
    wait_valid("t3_marker_valid");
    check("t3_count0", 32'(count), 0);
    for (int v = 0; v < DEPTH; v++) put(16'(v));
    check("t3_count_full", 32'(count), DEPTH);
    check("t3_full", {31'd0, full}, 1);
    check("t3_wr_ready", {31'd0, bus.wr_ready}, 0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h0055;
    step();
    bus.wr_valid = 1'b0;
    check("t3_rejected_count", 32'(count), DEPTH);
    check("t3_no_overflow", {31'd0, overflow}, 0);
    drain(40);
    check("t3_nread", got.size(), DEPTH + 1);
    check("t3_marker", 32'(got[0]), 32'hA5A5);
    check("t3_first", 32'(got[1]), 0);
    check("t3_last", 32'(got[DEPTH]), DEPTH - 1);

    // Circular record: DEPTH+2 writes of 0..DEPTH+1 behind a parked marker.
    clear = 1'b1;
    step();
    clear = 1'b0;
    overwrite = 1'b1;
    put(16'hA5A5);
    wait_valid("t4_marker_valid");
    ov_cnt = 0;
    for (int v = 0; v < DEPTH + 2; v++) begin
      put(16'(v));
      if (overflow) ov_cnt++;
    end
    check("t4_overflow_pulses", ov_cnt, 2);
    check("t4_count", 32'(count), DEPTH);
    check("t4_wr_ready_full", {31'd0, bus.wr_ready}, 1);
    step();
    check("t4_overflow_single", {31'd0, overflow}, 0);
    drain(40);
    check("t4_nread", got.size(), DEPTH + 1);
    check("t4_marker", 32'(got[0]), 32'hA5A5);
    check("t4_first_ram", 32'(got[1]), 2);
    check("t4_last", 32'(got[DEPTH]), DEPTH + 1);
    overwrite = 1'b0;

`ifdef SAMPLE_BUFFER_PEAK_EN
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("pk_clear", 32'(peak), 0);
    put(16'h0010);
    check("pk_0010", 32'(peak), 32'h0010);
    put(16'h8000);
    check("pk_8000", 32'(peak), 32'h7FFF);
    put(16'hFFF0);
    check("pk_fff0", 32'(peak), 32'h7FFF);
`endif

    // Asynchronous reset between edges with data in flight.
    put(16'h0007);
    put(16'h0008);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_rd_valid", {31'd0, bus.rd_valid}, 0);
    check("arst_rd_data", 32'(bus.rd_data), 0);
    check("arst_empty", {31'd0, empty}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_sample_buffer.md
BANKED_SAMPLE_BUFFER -- requirements
Module: banked_sample_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width in bits, treated as signed.
REQ-002 SHALL have parameter NUM_BANKS, default 4: number of single-port RAM banks, power of 2, at least 1.
REQ-003 SHALL have parameter BANK_DEPTH, default 16384: words per bank, power of 2; DEPTH = NUM_BANKS*BANK_DEPTH, AW = clog2(DEPTH).
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush of pointers and state.
REQ-007 SHALL have port overwrite, input, 1 bit: 1 = circular record (drop oldest when full), 0 = stop when full.
REQ-008 SHALL have port wr_valid, input, 1 bit, and wr_data, input, DATA_W bits: producer sample.
REQ-009 SHALL have port wr_ready, output, 1 bit: a write is accepted on wr_valid & wr_ready.
REQ-010 SHALL have port rd_valid, output, 1 bit, and rd_data, output, DATA_W bits: consumer sample.
REQ-011 SHALL have port rd_ready, input, 1 bit: a sample is delivered on rd_valid & rd_ready.
REQ-012 SHALL have port count, output, AW+1 bits: RAM occupancy, excluding the output register.
REQ-013 SHALL have ports full, empty and overflow, outputs, 1 bit each; overflow is a single-cycle pulse.

Function
REQ-014 SHALL split each pointer into bank = ptr[AW-1 -: log2(NUM_BANKS)] and offset = the remaining low bits; pointers wrap from DEPTH-1 to 0.
REQ-015 SHALL drive wr_ready = ~full | overwrite.
REQ-016 SHALL, on an accepted write, write wr_data at wr_ptr, increment wr_ptr, and increment count unless full.
REQ-017 SHALL, on an accepted write while full with overwrite=1, advance rd_ptr, leave count at DEPTH, and pulse overflow for 1 cycle.
REQ-018 SHALL use a read FSM with states IDLE (output register empty), FETCH (RAM read issued) and VALID (rd_valid=1, rd_data held stable).
REQ-019 SHALL move IDLE->FETCH when count>0 and there is no bank conflict; a fetch pops one word (rd_ptr+1, count-1).
REQ-020 SHALL move FETCH->VALID one cycle later, capturing RAM data into rd_data; RAM read latency is 1 cycle.
REQ-021 SHALL move VALID->FETCH on rd_ready when count>0 and there is no conflict, else VALID->IDLE on rd_ready; maximum read throughput is 1 sample per 2 cycles.
REQ-022 SHALL treat a same-cycle write and fetch to the same bank as a conflict: the write wins and the fetch is deferred 1 cycle; different banks proceed in parallel.
REQ-023 SHALL, when a fetch and a write coincide, apply both to count (net 0); full/empty SHALL reflect the updated count in the next cycle.
REQ-024 SHALL give clear priority over all activity: pointers and count go to 0, FSM to IDLE, rd_valid to 0, and any write that cycle is ignored.
REQ-025 SHALL assert full = (count==DEPTH) and empty = (count==0) combinationally from count.

Reset
REQ-026 SHALL, on reset_n low, asynchronously set wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE, rd_valid=0, rd_data=0, overflow=0, full=0, empty=1, wr_ready=1.
REQ-027 SHALL discard an in-flight fetch on reset or clear; RAM contents SHALL NOT be initialised.

Configuration
REQ-028 SHALL, with SAMPLE_BUFFER_PEAK_EN defined, add output peak (DATA_W-1 bits) = running maximum |wr_data| over accepted writes, with |most-negative| saturating to 2^(DATA_W-1)-1, zeroed by reset and clear.
REQ-029 SHALL, without SAMPLE_BUFFER_PEAK_EN, omit the peak port and logic entirely.

Structure
REQ-030 SHALL place the FSM state enum and the default DATA_W/NUM_BANKS/BANK_DEPTH constants in package sample_buffer_pkg.
REQ-031 SHALL instantiate NUM_BANKS copies of sub-module ram_bank (single-port, 1-cycle read, per-bank write enable); it maps to SP256K with all byte lanes write-enabled at the default sizes.

Verification
REQ-032 SHALL cover: reset, write 3 samples 0x0001..0x0003, rd_ready=1 -> rd_data 1,2,3 in order, each rd_valid pulse 2 cycles apart, count ends at 0.
REQ-033 SHALL cover: overwrite=0 with DEPTH writes -> full=1, wr_ready=0; the next write is not accepted and count stays at DEPTH.
REQ-034 SHALL cover: overwrite=1 with DEPTH+2 writes of values 0..DEPTH+1 -> overflow pulses twice, and first read returns 2.
REQ-035 SHALL cover: a write and a fetch targeting the same bank in one cycle -> the write completes, the fetch occurs 1 cycle later, and data integrity is preserved.
REQ-036 SHALL cover: clear asserted while in VALID with count=5 -> next cycle rd_valid=0, count=0, empty=1.
REQ-037 SHALL cover, with SAMPLE_BUFFER_PEAK_EN: writes 0x0010, 0x8000, 0xFFF0 -> peak = 0x7FFF.
